// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset/lock sequencing with retry, lock qualification and system reset release
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 27000,
  parameter int LOCK_STABLE_CYCLES = 2700,
  parameter int MAX_RETRIES        = 7
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic       unlock_evt
);
  localparam int MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_C = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CW    = (MAX_C > 2) ? $clog2(MAX_C) : 1;
  typedef enum logic [2:0] {PLLRST, WAIT_LOCK, STABLE, RUN, FAILED} state_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    retry_n;
  logic [1:0]    sync;
  logic          lock_s, unlock_n;
  assign lock_s = sync[1];
  // two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) sync <= 2'b00;
    else sync <= {sync[0], pll_lock};
  end
  // next state, retry budget and unlock pulse; restart overrides everything
  always_comb begin
    state_n  = state;
    retry_n  = retry_cnt;
    unlock_n = 1'b0;
    if (restart) begin
      state_n = PLLRST;
      retry_n = '0;
    end else begin
      case (state)
        PLLRST:    if (cnt == CW'(PLL_RST_CYCLES - 1)) state_n = WAIT_LOCK;
        WAIT_LOCK: begin
          if (lock_s) state_n = STABLE;
          else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            if (retry_cnt == 4'(MAX_RETRIES)) state_n = FAILED;
            else begin
              retry_n = retry_cnt + 4'd1;
              state_n = PLLRST;
            end
          end
        end
        STABLE: begin
          if (!lock_s) state_n = WAIT_LOCK;
          else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
            state_n = RUN;
            retry_n = '0;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_n  = PLLRST;
            unlock_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    cnt_n = (restart || state_n != state) ? '0 : cnt + CW'(1);
  end
  // state, counter and registered outputs decoded from the state being entered
  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state      <= PLLRST;
      cnt        <= '0;
      retry_cnt  <= '0;
      pll_reset  <= 1'b1;
      sys_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
      unlock_evt <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      retry_cnt  <= retry_n;
      pll_reset  <= (state_n == PLLRST) || (state_n == FAILED);
      sys_rst    <= state_n != RUN;
      ready      <= state_n == RUN;
      fail       <= state_n == FAILED;
      unlock_evt <= unlock_n;
    end
  end
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: scoreboard bench for pll_lock_supervisor with directed and random lock stimulus
module tb_pll_lock_supervisor;
  localparam int PRC = 4, TO = 20, LSC = 8, MR = 2;
  logic clkin = 0, reset = 1, pll_lock = 0, restart = 0;
  logic pll_reset, sys_rst, ready, fail, unlock_evt;
  logic [3:0] retry_cnt;
  pll_lock_supervisor #(.PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO), .LOCK_STABLE_CYCLES(LSC), .MAX_RETRIES(MR)) dut (
    .clkin(clkin), .reset(reset), .pll_lock(pll_lock), .restart(restart),
    .pll_reset(pll_reset), .sys_rst(sys_rst), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt), .unlock_evt(unlock_evt)
  );
  always #5 clkin = ~clkin;
  int n_chk = 0, n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e_v, g_v;
  typedef enum {P_RST, P_WAIT, P_STAB, P_RUN, P_FAIL} ph_t;
  ph_t ph = P_RST;
  int  t = 0, tries = 0;
  bit  s1 = 0, s2 = 0, rst_drv = 1;
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask
  task automatic m_reset();
    ph = P_RST; t = 0; tries = 0; s1 = 0; s2 = 0;
  endtask
  function automatic logic [8:0] m_out(input bit ue);
    return {ph == P_RST || ph == P_FAIL, ph != P_RUN, ph == P_RUN, ph == P_FAIL, ue, 4'(tries)};
  endfunction
  task automatic m_step(input bit lk, input bit rs);
    ph_t nx;
    bit  ls, ue;
    ls = s2; s2 = s1; s1 = lk; nx = ph; ue = 0;
    if (rs) begin nx = P_RST; tries = 0; end
    else if (ph == P_RST && t == PRC - 1) nx = P_WAIT;
    else if (ph == P_WAIT && ls) nx = P_STAB;
    else if (ph == P_WAIT && t == TO - 1) begin
      if (tries == MR) nx = P_FAIL;
      else begin tries++; nx = P_RST; end
    end
    else if (ph == P_STAB && !ls) nx = P_WAIT;
    else if (ph == P_STAB && t == LSC - 1) begin nx = P_RUN; tries = 0; end
    else if (ph == P_RUN && !ls) begin nx = P_RST; ue = 1; end
    t  = (rs || nx != ph) ? 0 : t + 1;
    ph = nx;
    exp_q.push_back(m_out(ue));
  endtask
  task automatic tick(input bit lk, input bit rs);
    @(negedge clkin);
    reset = rst_drv; pll_lock = lk; restart = rs;
    @(posedge clkin);
    if (reset) begin m_reset(); exp_q.push_back(m_out(0)); end
    else m_step(lk, rs);
    #1;
  endtask
  task automatic wait_fall(input bit lk, output int n);
    n = 0;
    do begin tick(lk, 0); n++; end while (pll_reset && n < 100);
  endtask
  task automatic wait_ready(input bit lk, output int n);
    n = 0;
    while (!ready && n < 200) begin tick(lk, 0); n++; end
  endtask
  // monitor: compare every registered output set against the queued expectation
  always @(posedge clkin) begin
    #1;
    if (exp_q.size() > 0) begin
      e_v = exp_q.pop_front();
      g_v = {pll_reset, sys_rst, ready, fail, unlock_evt, retry_cnt};
      n_chk++;
      if (g_v !== e_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got pr/sr/rdy/fail/ue/rc=%b, required %b", $time, g_v, e_v);
      end
    end
  end
  initial begin
    int n, ue, run;
    bit lk;
    repeat (3) tick(0, 0);
    rst_drv = 0;
    wait_fall(0, n);
    chk("pll_reset_width", n, PRC);
    repeat (5) tick(0, 0);
    tick(1, 0);
    wait_ready(1, n);
    chk("release_latency", n, LSC + 2);
    chk("run_retry_cnt", retry_cnt, 0);
    chk("run_sys_rst", sys_rst, 0);
    ue = 0; n = 0;
    do begin tick(0, 0); ue += unlock_evt; n++; end while (!pll_reset && n < 20);
    chk("unlock_latency", n, 3);
    chk("unlock_ready", ready, 0);
    chk("unlock_sys_rst", sys_rst, 1);
    n = 0;
    while (pll_reset && n < 20) begin tick(1, 0); ue += unlock_evt; n++; end
    chk("unlock_pll_reset_width", n, PRC);
    chk("unlock_pulses", ue, 1);
    wait_ready(1, n);
    chk("recover_ready", ready, 1);
    n = 0;
    while (!fail && n < 300) begin tick(0, 0); n++; end
    chk("ticks_to_fail", n, 3 + (MR + 1) * (PRC + TO));
    chk("fail_retry_cnt", retry_cnt, MR);
    repeat (6) tick(1'($urandom_range(0, 1)), 0);
    chk("fail_held", fail, 1);
    chk("fail_pll_reset", pll_reset, 1);
    tick(0, 1);
    chk("restart_fail", fail, 0);
    chk("restart_retry", retry_cnt, 0);
    wait_fall(0, n);
    chk("restart_pll_reset_width", n, PRC);
    repeat (5) tick(1, 0);
    repeat (3) tick(0, 0);
    tick(1, 0);
    wait_ready(1, n);
    chk("bounce_latency", n, LSC + 2);
    chk("bounce_retry", retry_cnt, 0);
    tick(1, 1);
    wait_fall(1, n);
    repeat (3) tick(1, 0);
    @(negedge clkin);
    #2;
    reset = 1; rst_drv = 1;
    #1;
    m_reset();
    chk("async_pll_reset", pll_reset, 1);
    chk("async_sys_rst", sys_rst, 1);
    chk("async_ready", ready, 0);
    chk("async_fail", fail, 0);
    chk("async_retry", retry_cnt, 0);
    chk("async_unlock", unlock_evt, 0);
    repeat (2) tick(1, 0);
    rst_drv = 0;
    wait_fall(0, n);
    chk("race_pll_reset_width", n, PRC);
    repeat (TO - 3) tick(0, 0);
    repeat (3) tick(1, 0);
    chk("race_pll_reset", pll_reset, 0);
    chk("race_retry", retry_cnt, 0);
    chk("race_sys_rst", sys_rst, 1);
    run = 0; lk = 1;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        lk  = $urandom_range(0, 3) != 0;
        run = $urandom_range(1, 30);
      end
      run--;
      tick(lk, $urandom_range(0, 49) == 0);
    end
    @(posedge clkin);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
